// File: rtl/rifl_tx_slot_scheduler.sv
// rifl_tx_slot_scheduler
//   Picks the type of each outgoing TX frame slot for one RIFL lane
//   (NOT_READY / RETRANS / PAUSE / DATA / IDLE). It arbitrates local
//   retransmit requests, local RX-buffer flow control, remote pause and
//   retransmit requests, and user data availability. It also drives the
//   rewind pulse of the TX retransmit buffer.
//
// Ports
//   clk, rst            TX frame clock; asynchronous active-high reset
//   rx_up               link receive-up, already synchronous to clk
//   rxbuffer_cnt        RX user buffer fill level
//   local_retrans_req   pulse: local CRC error, ask remote to retransmit
//   remote_pause_req    level: remote asks us to stop sending data
//   remote_retrans_req  pulse: remote asks us to retransmit
//   data_avail          a frame is ready for transmission
//   slot_req            pulse: framer asks for the next slot type
//   slot_type/slot_vld  decision, valid one cycle after slot_req
//                       (0 IDLE, 1 DATA, 2 PAUSE, 3 RETRANS, 4 NOT_READY)
//   rewind              one-cycle pulse to the retransmit buffer
//   pause_active        local pause status (hysteresis on rxbuffer_cnt)
//   stat_*_cnt          16-bit saturating statistics
//
// Build option
//   RIFL_SCHED_STATS_EN  enables the statistics counters; without it the
//                        stat ports are tied to zero.
module rifl_tx_slot_scheduler #(
  parameter int unsigned BUFFER_DEPTH    = 512,
  parameter int unsigned PAUSE_ON_VAL    = 2 * BUFFER_DEPTH / 3,
  parameter int unsigned PAUSE_OFF_VAL   = BUFFER_DEPTH / 3,
  parameter int unsigned PAUSE_REFRESH   = 16,
  parameter int unsigned REWIND_SLOTS    = 4,
  parameter int unsigned RETRANS_HOLDOFF = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_up,
  input  logic [$clog2(BUFFER_DEPTH):0] rxbuffer_cnt,
  input  logic                          local_retrans_req,
  input  logic                          remote_pause_req,
  input  logic                          remote_retrans_req,
  input  logic                          data_avail,
  input  logic                          slot_req,
  output logic [2:0]                    slot_type,
  output logic                          slot_vld,
  output logic                          rewind,
  output logic                          pause_active,
  output logic [15:0]                   stat_retrans_cnt,
  output logic [15:0]                   stat_pause_cnt,
  output logic [15:0]                   stat_rewind_cnt
);

  localparam int unsigned CNT_W  = $clog2(BUFFER_DEPTH) + 1;
  localparam int unsigned REF_W  = $clog2(PAUSE_REFRESH + 1);
  localparam int unsigned HOLD_W = $clog2(RETRANS_HOLDOFF + 1);
  localparam int unsigned REW_W  = $clog2(REWIND_SLOTS + 1);

  localparam logic [2:0] SLOT_IDLE      = 3'd0;
  localparam logic [2:0] SLOT_DATA      = 3'd1;
  localparam logic [2:0] SLOT_PAUSE     = 3'd2;
  localparam logic [2:0] SLOT_RETRANS   = 3'd3;
  localparam logic [2:0] SLOT_NOT_READY = 3'd4;

  typedef enum logic [1:0] {
    ST_DOWN,
    ST_RUN,
    ST_REWIND
  } state_t;

  state_t              state;
  logic                pause_due;
  logic                retrans_pend;
  logic [REF_W-1:0]    refresh_cnt;
  logic [HOLD_W-1:0]   holdoff_cnt;
  logic [REW_W-1:0]    rewind_cnt;

  logic                link_ok;
  logic                retrans_now;
  logic                rewind_set;
  logic                rewinding;
  logic                pause_next;
  logic [2:0]          slot_sel;
  logic                issue_retrans;
  logic                issue_pause;

  // Slot decision from current state plus same-cycle request pulses.
  always_comb begin
    link_ok     = rx_up && (state != ST_DOWN);
    retrans_now = retrans_pend || (local_retrans_req && (holdoff_cnt == '0));
    rewind_set  = link_ok && remote_retrans_req;
    // A remote retransmit seen this cycle already forbids DATA.
    rewinding   = (state == ST_REWIND) || rewind_set;

    if (rxbuffer_cnt >= CNT_W'(PAUSE_ON_VAL)) begin
      pause_next = 1'b1;
    end else if (rxbuffer_cnt <= CNT_W'(PAUSE_OFF_VAL)) begin
      pause_next = 1'b0;
    end else begin
      pause_next = pause_active;
    end

    if (!link_ok) begin
      slot_sel = SLOT_NOT_READY;
    end else if (retrans_now) begin
      slot_sel = SLOT_RETRANS;
    end else if (pause_due) begin
      slot_sel = SLOT_PAUSE;
    end else if (remote_pause_req || !data_avail || rewinding) begin
      slot_sel = SLOT_IDLE;
    end else begin
      slot_sel = SLOT_DATA;
    end

    issue_retrans = slot_req && (slot_sel == SLOT_RETRANS);
    issue_pause   = slot_req && (slot_sel == SLOT_PAUSE);
  end

  // Link FSM, pending flags, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_DOWN;
      slot_type    <= SLOT_IDLE;
      slot_vld     <= 1'b0;
      rewind       <= 1'b0;
      pause_active <= 1'b0;
      pause_due    <= 1'b0;
      retrans_pend <= 1'b0;
      refresh_cnt  <= '0;
      holdoff_cnt  <= '0;
      rewind_cnt   <= '0;
    end else begin
      slot_vld     <= slot_req;
      rewind       <= rewind_set;
      pause_active <= pause_next;
      if (slot_req) begin
        slot_type <= slot_sel;
      end

      // Holdoff ages per slot; a RETRANS slot rearms it.
      if (issue_retrans) begin
        holdoff_cnt <= HOLD_W'(RETRANS_HOLDOFF);
      end else if (slot_req && (holdoff_cnt != '0)) begin
        holdoff_cnt <= holdoff_cnt - HOLD_W'(1);
      end

      if (!link_ok) begin
        state        <= (state == ST_DOWN && rx_up) ? ST_RUN : ST_DOWN;
        pause_due    <= 1'b0;
        retrans_pend <= 1'b0;
        refresh_cnt  <= '0;
        rewind_cnt   <= '0;
      end else begin
        // A request coinciding with a RETRANS issue is swallowed.
        if (issue_retrans) begin
          retrans_pend <= 1'b0;
        end else if (retrans_now) begin
          retrans_pend <= 1'b1;
        end

        if (!pause_next) begin
          pause_due   <= 1'b0;
          refresh_cnt <= '0;
        end else if (!pause_active) begin
          pause_due   <= 1'b1;
          refresh_cnt <= '0;
        end else if (issue_pause) begin
          pause_due   <= 1'b0;
          refresh_cnt <= '0;
        end else if (slot_req && !pause_due) begin
          refresh_cnt <= refresh_cnt + REF_W'(1);
          if ((refresh_cnt + REF_W'(1)) == REF_W'(PAUSE_REFRESH - 1)) begin
            pause_due <= 1'b1;
          end
        end

        if (rewind_set) begin
          state      <= ST_REWIND;
          rewind_cnt <= REW_W'(REWIND_SLOTS);
        end else if ((state == ST_REWIND) && slot_req) begin
          rewind_cnt <= rewind_cnt - REW_W'(1);
          if (rewind_cnt <= REW_W'(1)) begin
            state <= ST_RUN;
          end
        end
      end
    end
  end

`ifdef RIFL_SCHED_STATS_EN
  // Saturating event counters, cleared while the link is down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_retrans_cnt <= '0;
      stat_pause_cnt   <= '0;
      stat_rewind_cnt  <= '0;
    end else if (!link_ok) begin
      stat_retrans_cnt <= '0;
      stat_pause_cnt   <= '0;
      stat_rewind_cnt  <= '0;
    end else begin
      if (issue_retrans && (stat_retrans_cnt != 16'hFFFF)) begin
        stat_retrans_cnt <= stat_retrans_cnt + 16'd1;
      end
      if (issue_pause && (stat_pause_cnt != 16'hFFFF)) begin
        stat_pause_cnt <= stat_pause_cnt + 16'd1;
      end
      if (rewind_set && (stat_rewind_cnt != 16'hFFFF)) begin
        stat_rewind_cnt <= stat_rewind_cnt + 16'd1;
      end
    end
  end
`else
  assign stat_retrans_cnt = '0;
  assign stat_pause_cnt   = '0;
  assign stat_rewind_cnt  = '0;
`endif

endmodule

// File: tb/tb_rifl_tx_slot_scheduler.sv
// Self-checking bench for rifl_tx_slot_scheduler: directed scenarios
// followed by randomized traffic, compared every cycle against a
// behavioural slot model kept in plain integers.
module tb_rifl_tx_slot_scheduler;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int ON_VAL   = 2 * DEPTH / 3;
  localparam int OFF_VAL  = DEPTH / 3;
  localparam int REFRESH  = 16;
  localparam int REW_SL   = 4;
  localparam int HOLDOFF  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_up;
  logic [CW-1:0] rxbuffer_cnt;
  logic          local_retrans_req;
  logic          remote_pause_req;
  logic          remote_retrans_req;
  logic          data_avail;
  logic          slot_req;
  logic [2:0]    slot_type;
  logic          slot_vld;
  logic          rewind;
  logic          pause_active;
  logic [15:0]   stat_retrans_cnt;
  logic [15:0]   stat_pause_cnt;
  logic [15:0]   stat_rewind_cnt;

  always #5 clk = ~clk;

  rifl_tx_slot_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .rx_up              (rx_up),
    .rxbuffer_cnt       (rxbuffer_cnt),
    .local_retrans_req  (local_retrans_req),
    .remote_pause_req   (remote_pause_req),
    .remote_retrans_req (remote_retrans_req),
    .data_avail         (data_avail),
    .slot_req           (slot_req),
    .slot_type          (slot_type),
    .slot_vld           (slot_vld),
    .rewind             (rewind),
    .pause_active       (pause_active),
    .stat_retrans_cnt   (stat_retrans_cnt),
    .stat_pause_cnt     (stat_pause_cnt),
    .stat_rewind_cnt    (stat_rewind_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: link up flag, rewind window, pause bookkeeping.
  bit m_up, m_in_rewind, m_pa, m_due, m_pend;
  int m_rew_left, m_since_pause, m_hold;
  int m_st_rt, m_st_p, m_st_rw;
  bit e_vld, e_rewind;
  int e_type;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_up = 0; m_in_rewind = 0; m_pa = 0; m_due = 0; m_pend = 0;
    m_rew_left = 0; m_since_pause = 0; m_hold = 0;
    m_st_rt = 0; m_st_p = 0; m_st_rw = 0;
    e_vld = 0; e_rewind = 0; e_type = 0;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One clock edge of the specification's rules.
  task automatic model_step();
    bit link, req_ok, new_pa;
    int t;
    link   = m_up && rx_up;
    req_ok = local_retrans_req && (m_hold == 0);
    if (!link)                                   t = 4;
    else if (m_pend || req_ok)                   t = 3;
    else if (m_due)                              t = 2;
    else if (remote_pause_req || !data_avail ||
             m_in_rewind || remote_retrans_req)  t = 0;
    else                                         t = 1;

    e_vld    = slot_req;
    e_rewind = 0;
    if (slot_req) e_type = t;

    if (int'(rxbuffer_cnt) >= ON_VAL)       new_pa = 1;
    else if (int'(rxbuffer_cnt) <= OFF_VAL) new_pa = 0;
    else                                    new_pa = m_pa;

    if (slot_req) begin
      if (t == 3) m_hold = HOLDOFF;
      else if (m_hold > 0) m_hold--;
    end

    if (!link) begin
      m_up = !m_up && rx_up;
      m_pend = 0; m_due = 0; m_since_pause = 0;
      m_in_rewind = 0; m_rew_left = 0;
      m_st_rt = 0; m_st_p = 0; m_st_rw = 0;
    end else begin
      if (slot_req && t == 3) m_pend = 0;
      else if (req_ok)        m_pend = 1;
      if (slot_req && t == 3) m_st_rt = sat16(m_st_rt + 1);
      if (slot_req && t == 2) m_st_p  = sat16(m_st_p + 1);

      if (!new_pa) begin
        m_due = 0; m_since_pause = 0;
      end else if (!m_pa) begin
        m_due = 1; m_since_pause = 0;
      end else if (slot_req) begin
        if (t == 2) begin
          m_due = 0; m_since_pause = 0;
        end else if (!m_due) begin
          m_since_pause++;
          if (m_since_pause == REFRESH - 1) m_due = 1;
        end
      end

      if (remote_retrans_req) begin
        e_rewind = 1; m_in_rewind = 1; m_rew_left = REW_SL;
        m_st_rw = sat16(m_st_rw + 1);
      end else if (m_in_rewind && slot_req) begin
        m_rew_left--;
        if (m_rew_left == 0) m_in_rewind = 0;
      end
    end
    m_pa = new_pa;
  endtask

  task automatic check_outputs();
    check("slot_vld", slot_vld, e_vld);
    check("slot_type", slot_type, e_type);
    check("rewind", rewind, e_rewind);
    check("pause_active", pause_active, m_pa);
`ifdef RIFL_SCHED_STATS_EN
    check("stat_retrans", stat_retrans_cnt, m_st_rt);
    check("stat_pause", stat_pause_cnt, m_st_p);
    check("stat_rewind", stat_rewind_cnt, m_st_rw);
`else
    check("stat_retrans", stat_retrans_cnt, 0);
    check("stat_pause", stat_pause_cnt, 0);
    check("stat_rewind", stat_rewind_cnt, 0);
`endif
  endtask

  // Advance one clock: model and DUT see the same inputs; pulses drop after.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    slot_req = 0;
    local_retrans_req = 0;
    remote_retrans_req = 0;
  endtask

  task automatic slot4();
    slot_req = 1;
    tick();
    repeat (3) tick();
  endtask

  initial begin
    int down_left;
    rst = 1; rx_up = 0; rxbuffer_cnt = '0; local_retrans_req = 0;
    remote_pause_req = 0; remote_retrans_req = 0; data_avail = 0; slot_req = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 0;

    // Link down: every slot is NOT_READY.
    repeat (3) slot4();
    check("down_slot_type", slot_type, 4);

    // Plain data, then remote pause forces IDLE.
    rx_up = 1; data_avail = 1;
    tick();
    repeat (6) slot4();
    check("data_slot_type", slot_type, 1);
    remote_pause_req = 1;
    repeat (3) slot4();
    check("remote_pause_idle", slot_type, 0);
    remote_pause_req = 0;

    // Local pause hysteresis and periodic refresh.
    rxbuffer_cnt = CW'(300);
    repeat (2) slot4();
    rxbuffer_cnt = CW'(341);
    repeat (40) slot4();
    rxbuffer_cnt = CW'(200);
    repeat (20) slot4();
    check("pause_hold_mid", pause_active, 1);
    rxbuffer_cnt = CW'(170);
    repeat (20) slot4();
    check("pause_cleared", pause_active, 0);

    // RETRANS beats a due PAUSE; a later request falls in the holdoff.
    rxbuffer_cnt = CW'(341);
    tick();
    local_retrans_req = 1; slot_req = 1;
    tick();
    check("retrans_first", slot_type, 3);
    repeat (3) tick();
    slot4();
    check("pause_after_retrans", slot_type, 2);
    repeat (9) slot4();
    local_retrans_req = 1;
    slot4();
    slot4();
    check("retrans_dropped", (slot_type == 3) ? 1 : 0, 0);
`ifdef RIFL_SCHED_STATS_EN
    check("stat_retrans_one", stat_retrans_cnt, 1);
`endif
    repeat (70) slot4();
    local_retrans_req = 1;
    tick();
    slot4();
    check("retrans_after_holdoff", slot_type, 3);
    rxbuffer_cnt = CW'(0);
    repeat (2) slot4();

    // Remote retransmit: rewind pulse and a window of non-data slots.
    repeat (2) slot4();
    remote_retrans_req = 1;
    tick();
    repeat (2) slot4();
    remote_retrans_req = 1;
    tick();
    repeat (6) slot4();
    check("data_after_rewind", slot_type, 1);
    slot_req = 1; remote_retrans_req = 1;
    tick();
    check("coincident_rr_idle", slot_type, 0);
    repeat (6) slot4();

    // Randomized traffic.
    down_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (down_left > 0) begin
        rx_up = 0; down_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        rx_up = 0; down_left = int'($urandom_range(1, 5));
      end else begin
        rx_up = 1;
      end
      slot_req           = ($urandom_range(0, 2) == 0);
      local_retrans_req  = ($urandom_range(0, 24) == 0);
      remote_retrans_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) remote_pause_req = ~remote_pause_req;
      data_avail         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) rxbuffer_cnt = CW'($urandom_range(0, DEPTH));
      tick();
    end

    // rx_up drops in REWIND, then async reset kills an in-flight slot.
    rx_up = 1; data_avail = 1; remote_pause_req = 0; rxbuffer_cnt = CW'(0);
    repeat (2) tick();
    remote_retrans_req = 1;
    tick();
    slot4();
    rx_up = 0; slot_req = 1;
    tick();
    check("drop_not_ready", slot_type, 4);
    repeat (2) tick();
    slot_req = 1;
    tick();
    #1 rst = 1;
    #1;
    check("rst_kills_vld", slot_vld, 0);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 0;
    slot4();
    check("post_rst_not_ready", slot_type, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rifl_tx_slot_scheduler.md
Name: rifl_tx_slot_scheduler

Overview:
- Decides the type of each outgoing TX frame slot in a RIFL lane: NOT_READY, RETRANS request, PAUSE request, DATA or IDLE.
- Arbitrates between:
  - local retransmit requests from the RX CRC path,
  - local flow control derived from RX user-buffer occupancy,
  - remote pause and retransmit requests,
  - user data availability.
- Sits in the TX frame clock domain, between the RX CDC outputs and the TX framer; drives the rewind pulse of the TX retransmit buffer.

Parameters:
- BUFFER_DEPTH, 512, RX user buffer depth; rxbuffer_cnt width is $clog2(BUFFER_DEPTH)+1.
- PAUSE_ON_VAL, 2*BUFFER_DEPTH/3, occupancy at or above which local pause asserts.
- PAUSE_OFF_VAL, BUFFER_DEPTH/3, occupancy at or below which local pause deasserts.
- PAUSE_REFRESH, 16, slots between repeated PAUSE frames while pause is active.
- REWIND_SLOTS, 4, non-data slots issued after a remote retransmit request.
- RETRANS_HOLDOFF, 64, slots after a sent RETRANS during which new local retrans requests are dropped.

Ports:
- clk, in, 1, TX frame clock.
- rst, in, 1, reset; asynchronous, active-high.
- rx_up, in, 1, link receive-up (already synced to clk).
- rxbuffer_cnt, in, $clog2(BUFFER_DEPTH)+1, RX user buffer fill level.
- local_retrans_req, in, 1, pulse: local CRC error, ask remote to retransmit.
- remote_pause_req, in, 1, level: remote asks us to stop data.
- remote_retrans_req, in, 1, pulse: remote asks us to retransmit.
- data_avail, in, 1, retransmit/user buffer holds a frame.
- slot_req, in, 1, pulse: framer requests the type of the next slot.
- slot_type, out, 3, 0=IDLE, 1=DATA, 2=PAUSE, 3=RETRANS, 4=NOT_READY; 5-7 never driven.
- slot_vld, out, 1, slot_type valid.
- rewind, out, 1, one-cycle pulse to the retransmit buffer.
- pause_active, out, 1, local pause status.
- stat_retrans_cnt / stat_pause_cnt / stat_rewind_cnt, out, 16 each, statistics.

Behaviour:
- Reset values: all outputs 0; state DOWN; all pending flags and counters cleared.
- Latency: slot_vld asserts exactly 1 cycle after slot_req, for 1 cycle, with slot_type registered alongside. The decision uses state/flags as of the slot_req cycle, including same-cycle request pulses.
- pause_active hysteresis (registered):
  - set when rxbuffer_cnt >= PAUSE_ON_VAL;
  - cleared when rxbuffer_cnt <= PAUSE_OFF_VAL;
  - otherwise holds.
- pause_due:
  - set on the pause_active rising edge.
  - Refresh counter increments on each non-PAUSE slot while active; pause_due is set when the counter reaches PAUSE_REFRESH-1.
  - A PAUSE slot clears pause_due and zeroes the counter.
  - pause_active falling clears pause_due and the counter.
- retrans_pend:
  - set by local_retrans_req unless the holdoff counter is nonzero;
  - cleared when a RETRANS slot is issued, which also loads holdoff = RETRANS_HOLDOFF;
  - holdoff decrements per slot and saturates at 0.
- States:
  - DOWN:
    - every slot is NOT_READY; rewind held at 0; pend/due flags cleared.
    - -> RUN when rx_up=1.
  - RUN: slot priority is
    1. RETRANS if retrans_pend;
    2. PAUSE if pause_due;
    3. IDLE if remote_pause_req or !data_avail;
    4. otherwise DATA.
    - On remote_retrans_req: rewind pulses next cycle, rewind counter loads REWIND_SLOTS, state -> REWIND.
  - REWIND:
    - same priority as RUN, except DATA is replaced by IDLE;
    - counter decrements per slot; -> RUN after REWIND_SLOTS slots.
    - A further remote_retrans_req reloads the counter and re-pulses rewind.
- rx_up=0 in any state: -> DOWN on the next edge; a slot decided in that same cycle is already NOT_READY.
- Simultaneous events:
  - slot_req together with remote_retrans_req in RUN: that slot is IDLE, never DATA.
  - local_retrans_req together with a RETRANS slot issue: the new request is dropped by holdoff.
- rst mid-operation: immediate return to reset values; any in-flight slot_vld is killed.

Optional Feature:
- RIFL_SCHED_STATS_EN defined:
  - the three stat counters count issued RETRANS slots, issued PAUSE slots and rewind pulses;
  - 16-bit, saturating at 16'hFFFF; cleared by rst and on entry to DOWN.
- Undefined: stat ports remain present, tied to 0; no counter logic is instantiated.

Test Plan:
- Reset, rx_up=0, 3 slot_req -> three slot_vld each 1 cycle later with slot_type=4; rewind=0; all stats 0.
- rx_up=1, data_avail=1, slot_req every 4 cycles -> slot_type=1 on each slot; remote_pause_req=1 -> slot_type=0.
- rxbuffer_cnt 300 -> 341 (BUFFER_DEPTH=512):
  - pause_active=1 one cycle later; next slot is PAUSE;
  - following PAUSE every 16th slot;
  - cnt 200 keeps pause_active=1; cnt 170 clears it and no further PAUSE slots are issued.
- local_retrans_req in the same cycle as slot_req while pause_due -> that slot RETRANS, next slot PAUSE; local_retrans_req 10 slots later -> dropped (no RETRANS); stat_retrans_cnt=1 with the macro.
- remote_retrans_req in RUN with data_avail=1 -> rewind pulse 1 cycle later; 4 IDLE slots, then DATA; a second remote_retrans_req at slot 2 -> second rewind pulse and 4 more IDLE slots counted from there.
- rx_up drops mid-REWIND, then async rst mid-slot -> next slot is NOT_READY; rst clears slot_vld in the same cycle; all outputs 0.
